// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial frame constants and collector state encoding
//
// Purpose: definitions shared by the two's-complement stage, its serializer
// and the word collector, so that every block agrees on the frame format.
// Ports: none (package).

package serial_pkg;

  // Default word length of a serial frame.
  localparam int DEFAULT_WIDTH = 8;

  // Frames are sent least-significant bit first; sof marks bit index 0.
  localparam bit LSB_FIRST     = 1'b1;
  localparam int SOF_BIT_INDEX = 0;

  // Collector FSM: IDLE waits for sof, SHIFT is a frame in progress.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/sipo_bit_counter.sv
// rtl/sipo_bit_counter.sv - per-frame bit counter with terminal-count flag
//
// Purpose: counts bits accepted in the current frame, wrapping to 0 after
// the last bit of a word.
// Ports:
//   clk    in   1      clock, posedge
//   clr    in   1      synchronous clear to 0 (highest priority)
//   start  in   1      load 1: the bit being accepted is bit 0 of a new frame
//   en     in   1      count one accepted bit; wraps to 0 at terminal count
//   cnt    out  CNT_W  current count
//   tc     out  1      cnt == WIDTH-1 (next accepted bit completes the word)

module sipo_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc  = (cnt_q == CNT_W'(WIDTH - 1));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CNT_W'(1);
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_word_collector.sv
// rtl/sipo_word_collector.sv - collects LSB-first serial frames into parallel words
//
// Purpose: reassembles WIDTH-bit serial frames (sof on bit 0) into words and
// presents them on a valid/ready output register.
// Ports:
//   clk         in   1      clock, posedge
//   reset_n     in   1      synchronous reset, active-low
//   sin         in   1      serial data bit
//   sin_valid   in   1      sin carries a real bit this cycle
//   sof         in   1      start of frame, qualified by sin_valid
//   word_out    out  WIDTH  assembled word, bit 0 = first bit received
//   word_valid  out  1      word_out holds an unconsumed word
//   word_ready  in   1      consumer accepts word_out this cycle
//   busy        out  1      frame in progress
//   overrun     out  1      pulse: completed word dropped, output register full
//   frame_err   out  1      pulse: sof seen mid-frame, partial word discarded

module sipo_word_collector
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             cnt_start;
  logic             cnt_en;
  logic             cnt_tc;
  logic [CNT_W-1:0] bit_cnt;
  logic             complete;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .clr   (!reset_n),
    .start (cnt_start),
    .en    (cnt_en),
    .cnt   (bit_cnt),
    .tc    (cnt_tc)
  );

  // Frame FSM and shift register.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_start   = 1'b0;
    cnt_en      = 1'b0;
    complete    = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Bits outside a frame are ignored until sof arrives.
        if (sin_valid && sof) begin
          shift_d   = WIDTH'({sin, shift_q} >> 1);
          cnt_start = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          // Stale bits of an abandoned frame need no clearing: a full frame
          // of shifts pushes them all out before the word completes.
          shift_d = WIDTH'({sin, shift_q} >> 1);
          if (sof) begin
            frame_err_d = 1'b1;
            cnt_start   = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
              complete = 1'b1;
              state_d  = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register with valid/ready handshake.
  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end

    if (complete) begin
      // A word being consumed on this edge frees the register for the new one.
      if (!valid_q || word_ready) begin
        word_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign busy       = (state_q == SHIFT);
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

  // The counter value itself is observed only through its terminal flag.
  logic unused_cnt;
  assign unused_cnt = ^bit_cnt;

endmodule

// File: tb/tb_sipo_word_collector.sv
// tb/tb_sipo_word_collector.sv - self-checking bench for sipo_word_collector

module tb_sipo_word_collector;

  logic       clk;
  logic       reset_n;
  logic       sin;
  logic       sin_valid;
  logic       sof;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic       busy;
  logic       overrun;
  logic       frame_err;

  int n_assert;
  int n_fail;

  logic [7:0] exp_q[$];

  sipo_word_collector #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sof        (sof),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: a transfer happens on the next posedge whenever
  // word_valid && word_ready; inputs only change just after posedge.
  always @(negedge clk) begin
    if (reset_n && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {24'h0, word_out}, 32'hFFFF_FFFF);
      end else begin
        check("sb_word", {24'h0, word_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_frame(input logic [7:0] w, input int gap, input logic rdy,
                            input logic rdy_last, input logic exp_ovr,
                            input logic exp_ferr, input logic push);
    if (push) exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      word_ready = (i == 7) ? rdy_last : rdy;
      sin_valid  = 1'b1;
      sin        = w[i];
      sof        = (i == 0);
      step();
      check("frame_err", {31'h0, frame_err}, {31'h0, (i == 0) ? exp_ferr : 1'b0});
      if (i < 7) begin
        check("busy_mid", {31'h0, busy}, 32'h1);
        check("overrun_mid", {31'h0, overrun}, 32'h0);
      end else begin
        check("busy_done", {31'h0, busy}, 32'h0);
        check("overrun_done", {31'h0, overrun}, {31'h0, exp_ovr});
        check("valid_done", {31'h0, word_valid}, 32'h1);
      end
      sin_valid = 1'b0;
      sof       = 1'b0;
      if (i < 7) begin
        for (int g = 0; g < gap; g++) begin
          step();
          check("busy_gap", {31'h0, busy}, 32'h1);
        end
      end
    end
  endtask

  task automatic send_partial(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sin_valid = 1'b1;
      sin       = w[i];
      sof       = (i == 0);
      step();
      check("busy_partial", {31'h0, busy}, 32'h1);
    end
    sin_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word"},  {24'h0, word_out}, 32'h0);
    check({tag, "_valid"}, {31'h0, word_valid}, 32'h0);
    check({tag, "_busy"},  {31'h0, busy}, 32'h0);
    check({tag, "_ovr"},   {31'h0, overrun}, 32'h0);
    check({tag, "_ferr"},  {31'h0, frame_err}, 32'h0);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    sof        = 1'b0;
    word_ready = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    // Consecutive bits, consumer ready.
    send_frame(8'hF6, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("f6_word", {24'h0, word_out}, 32'hF6);
    step();
    check("f6_drop", {31'h0, word_valid}, 32'h0);

    // Same frame with 3-cycle gaps between bits.
    send_frame(8'hF6, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();

    // Back-to-back frames while the consumer stalls: second word dropped.
    send_frame(8'h01, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h80, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_hold_word", {24'h0, word_out}, 32'h01);
    step();
    check("ovr_pulse_end", {31'h0, overrun}, 32'h0);
    check("ovr_still_valid", {31'h0, word_valid}, 32'h1);
    word_ready = 1'b1;
    step();
    check("ovr_drained", {31'h0, word_valid}, 32'h0);

    // Completion and consumption on the same edge.
    send_frame(8'h01, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h80, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("swap_word", {24'h0, word_out}, 32'h80);
    step();
    check("swap_drained", {31'h0, word_valid}, 32'h0);

    // sof after four bits restarts the frame.
    word_ready = 1'b1;
    send_partial(8'hAA, 4);
    send_frame(8'h55, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check("ferr_pulse_end", {31'h0, frame_err}, 32'h0);

    // Reset in the middle of a frame while a word is held.
    send_frame(8'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_partial(8'hC3, 5);
    reset_n   = 1'b0;
    sin_valid = 1'b1;
    sin       = 1'b1;
    step();
    check_all_zero("midreset");
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sin_valid = 1'b1;
      sin       = 1'b1;
      sof       = 1'b0;
      step();
      check("nosof_busy", {31'h0, busy}, 32'h0);
      check("nosof_valid", {31'h0, word_valid}, 32'h0);
    end
    sin_valid = 1'b0;
    send_frame(8'hA5, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    repeat (3) step();
    check("sb_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
